// File: rtl/md_sequencer_pkg.sv
// Execute-stage constants and state encoding shared by the multdiv sequencer
// and any other unit that needs to recognise mul/div instructions.
package md_sequencer_pkg;

  localparam logic [4:0]  OPC_RTYPE = 5'b00000;
  localparam logic [4:0]  ALU_MUL   = 5'b00110;
  localparam logic [4:0]  ALU_DIV   = 5'b00111;
  localparam logic [31:0] EXC_MUL   = 32'd4;
  localparam logic [31:0] EXC_DIV   = 32'd5;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  function automatic logic [31:0] exc_code(input logic is_mul);
    return is_mul ? EXC_MUL : EXC_DIV;
  endfunction

endpackage

// File: rtl/md_decode.sv
// Combinational recogniser for R-type mul/div instructions.
module md_decode
  import md_sequencer_pkg::*;
(
  input  logic [31:0] insn_i,
  output logic        is_mul_o,
  output logic        is_div_o
);

  logic rtype_s;

  assign rtype_s  = (insn_i[31:27] == OPC_RTYPE);
  assign is_mul_o = rtype_s && (insn_i[6:2] == ALU_MUL);
  assign is_div_o = rtype_s && (insn_i[6:2] == ALU_DIV);

endmodule

// File: rtl/md_sequencer.sv
// Launches the multi-cycle multiplier/divider, stalls the front end while it
// works and hands its result (or exception code) to the X/M latch.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] insn_x,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        kill_x,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic [31:0] md_operand_a,
  output logic [31:0] md_operand_b,
  output logic        stall,
  output logic        bubble_xm,
  output logic        md_valid,
  output logic [31:0] md_out,
  output logic        md_write_exception
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_mul_q, op_mul_d;
  logic [31:0]      res_q, res_d;
  logic             exc_q, exc_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic             rst_q;
  logic             is_mul_s, is_div_s, is_md_s;
  logic             launch_s;
  logic             quiet_s;

  md_decode u_decode (
    .insn_i   (insn_x),
    .is_mul_o (is_mul_s),
    .is_div_o (is_div_s)
  );

  assign is_md_s = is_mul_s | is_div_s;
  // The cycle right after reset is kept silent, so nothing may launch in it.
  assign quiet_s  = reset | rst_q;
  assign launch_s = (state_q == MD_IDLE) && is_md_s && !kill_x && !quiet_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      op_mul_q <= 1'b0;
      res_q    <= 32'd0;
      exc_q    <= 1'b0;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      rst_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_mul_q <= op_mul_d;
      res_q    <= res_d;
      exc_q    <= exc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rst_q    <= 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_mul_d = op_mul_q;
    res_d    = res_q;
    exc_d    = exc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    case (state_q)
      MD_IDLE: begin
        if (launch_s) begin
          state_d  = MD_BUSY;
          cnt_d    = '0;
          op_mul_d = is_mul_s;
          opa_d    = operand_a;
          opb_d    = operand_b;
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A squash wins over everything; a completion wins over the timeout.
        if (kill_x) begin
          state_d = MD_IDLE;
        end else if (md_ready) begin
          state_d = MD_DONE;
          res_d   = md_result;
          exc_d   = md_exception;
        end else if (cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_d = MD_DONE;
          res_d   = 32'd0;
          exc_d   = 1'b1;
        end else begin
          state_d = MD_BUSY;
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    ctrl_mult          = 1'b0;
    ctrl_div           = 1'b0;
    stall              = 1'b0;
    bubble_xm          = 1'b0;
    md_valid           = 1'b0;
    md_out             = 32'd0;
    md_write_exception = 1'b0;
    md_operand_a       = 32'd0;
    md_operand_b       = 32'd0;
    if (quiet_s) begin
      stall = 1'b0;
    end else begin
      md_operand_a = opa_q;
      md_operand_b = opb_q;
      case (state_q)
        MD_IDLE: begin
          if (launch_s) begin
            ctrl_mult = is_mul_s;
            ctrl_div  = is_div_s;
            stall     = 1'b1;
            bubble_xm = 1'b1;
          end else begin
            stall = 1'b0;
          end
        end
        MD_BUSY: begin
          stall     = 1'b1;
          bubble_xm = 1'b1;
        end
        MD_DONE: begin
          if (!kill_x) begin
            md_valid           = 1'b1;
            md_out             = exc_q ? exc_code(op_mul_q) : res_q;
            md_write_exception = exc_q;
          end else begin
            md_valid = 1'b0;
          end
        end
        default: stall = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed scenarios with literal
// expectations followed by randomized traffic against a transaction model.
module tb_md_sequencer;

  localparam int MAXC = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] insn_x, operand_a, operand_b, md_result;
  logic        kill_x, md_exception, md_ready;
  logic        ctrl_mult, ctrl_div, stall, bubble_xm, md_valid, md_write_exception;
  logic [31:0] md_operand_a, md_operand_b, md_out;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int ready_at = -1;

  md_sequencer #(.MAX_CYCLES(MAXC), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .insn_x(insn_x),
    .operand_a(operand_a), .operand_b(operand_b), .kill_x(kill_x),
    .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
    .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
    .md_operand_a(md_operand_a), .md_operand_b(md_operand_b),
    .stall(stall), .bubble_xm(bubble_xm), .md_valid(md_valid),
    .md_out(md_out), .md_write_exception(md_write_exception)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  function automatic logic [31:0] mk_md(input logic mul);
    logic [19:0] f;
    f = 20'($urandom);
    return {5'b00000, f, (mul ? 5'b00110 : 5'b00111), 2'b00};
  endfunction

  function automatic logic [1:0] classify(input logic [31:0] insn);
    if (insn[31:27] != 5'b00000) return 2'd0;
    if (insn[6:2] == 5'b00110) return 2'd1;
    if (insn[6:2] == 5'b00111) return 2'd2;
    return 2'd0;
  endfunction

  // Transaction model: an in-flight operation and a pending result for X/M.
  bit          m_hold, m_busy, m_done, m_mul, m_exc;
  int          m_spent;
  logic [31:0] m_res, m_opa, m_opb;

  initial begin
    m_hold = 0; m_busy = 0; m_done = 0; m_mul = 0; m_exc = 0;
    m_spent = 0; m_res = 0; m_opa = 0; m_opb = 0;
  end

  always @(posedge clock) begin
    if (reset) begin
      m_hold = 1; m_busy = 0; m_done = 0; m_mul = 0; m_exc = 0;
      m_spent = 0; m_res = 0; m_opa = 0; m_opb = 0;
    end else if (m_hold) begin
      m_hold = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      m_spent++;
      if (kill_x) m_busy = 0;
      else if (md_ready) begin m_busy = 0; m_done = 1; m_res = md_result; m_exc = md_exception; end
      else if (m_spent == MAXC) begin m_busy = 0; m_done = 1; m_res = 0; m_exc = 1; end
    end else if (classify(insn_x) != 2'd0 && !kill_x) begin
      m_busy = 1; m_spent = 0; m_mul = (classify(insn_x) == 2'd1);
      m_opa = operand_a; m_opb = operand_b;
    end
  end

  always @(negedge clock) begin
    bit quiet, launch, e_valid;
    logic [5:0] e_ctl;
    logic [31:0] e_out;
    quiet   = reset || m_hold;
    launch  = !quiet && !m_busy && !m_done && classify(insn_x) != 2'd0 && !kill_x;
    e_valid = !quiet && m_done && !kill_x;
    e_ctl   = {launch && classify(insn_x) == 2'd1, launch && classify(insn_x) == 2'd2,
               !quiet && (launch || m_busy), !quiet && (launch || m_busy),
               e_valid, e_valid && m_exc};
    e_out   = e_valid ? (m_exc ? (m_mul ? 32'd4 : 32'd5) : m_res) : 32'd0;
    chk("ctl{mult,div,stall,bubble,valid,wexc}",
        {26'd0, ctrl_mult, ctrl_div, stall, bubble_xm, md_valid, md_write_exception}, {26'd0, e_ctl});
    if (!(m_done && kill_x && !quiet)) chk("md_out", md_out, e_out);
    chk("md_operand_a", md_operand_a, quiet ? 32'd0 : m_opa);
    chk("md_operand_b", md_operand_b, quiet ? 32'd0 : m_opb);
  end

  task automatic drv(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                     input logic k, input logic rdy, input logic [31:0] res, input logic exc);
    @(posedge clock); #1;
    insn_x = insn; operand_a = a; operand_b = b; kill_x = k;
    md_ready = rdy; md_result = res; md_exception = exc;
    @(negedge clock);
  endtask

  initial begin
    logic [31:0] mi, di, ins;
    bit hold;
    int r;
    reset = 1'b1; insn_x = 32'd0; operand_a = 32'd0; operand_b = 32'd0;
    kill_x = 1'b0; md_result = 32'd0; md_exception = 1'b0; md_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_out", md_out, 32'd0);

    // Cycle after reset is silent even with a mul waiting in X.
    mi = mk_md(1'b1);
    @(posedge clock); #1; reset = 1'b0; insn_x = mi; operand_a = 32'd7; operand_b = 32'd6;
    @(negedge clock);
    chk("post_reset_ctrl", {31'd0, ctrl_mult}, 32'd0);
    chk("post_reset_stall", {31'd0, stall}, 32'd0);

    // 1: mul 7*6, ready three cycles after the pulse.
    drv(mi, 32'd7, 32'd6, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("t1_pulse", {30'd0, ctrl_mult, stall}, 32'd3);
    drv(mi, 32'd7, 32'd6, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("t1_one_pulse", {31'd0, ctrl_mult}, 32'd0);
    chk("t1_opa", md_operand_a, 32'd7);
    chk("t1_opb", md_operand_b, 32'd6);
    drv(mi, 32'd7, 32'd6, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("t1_stall2", {31'd0, stall}, 32'd1);
    drv(mi, 32'd7, 32'd6, 1'b0, 1'b1, 32'd42, 1'b0);
    chk("t1_stall3", {31'd0, stall}, 32'd1);
    drv(mi, 32'd7, 32'd6, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("t1_done", {29'd0, md_valid, md_write_exception, stall}, 32'd4);
    chk("t1_out", md_out, 32'd42);

    // 2: div by zero right behind the mul, minimum latency.
    di = mk_md(1'b0);
    drv(di, 32'd100, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("t2_pulse", {30'd0, ctrl_mult, ctrl_div}, 32'd1);
    drv(di, 32'd100, 32'd0, 1'b0, 1'b1, 32'hdead_beef, 1'b1);
    chk("t2_opb", md_operand_b, 32'd0);
    drv(di, 32'd100, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("t2_done", {29'd0, md_valid, md_write_exception, stall}, 32'd6);
    chk("t2_out", md_out, 32'd5);

    // 3: mul that never completes times out after MAXC busy cycles.
    mi = mk_md(1'b1);
    drv(mi, 32'd3, 32'd3, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("t3_pulse", {31'd0, ctrl_mult}, 32'd1);
    for (int i = 0; i < MAXC; i++) begin
      drv(mi, 32'd3, 32'd3, 1'b0, 1'b0, 32'd0, 1'b0);
      if (stall !== 1'b1 || md_valid !== 1'b0) chk("t3_busy", {30'd0, stall, md_valid}, 32'd2);
    end
    drv(mi, 32'd3, 32'd3, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("t3_done", {29'd0, md_valid, md_write_exception, stall}, 32'd6);
    chk("t3_out", md_out, 32'd4);
    drv(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("t3_idle", {29'd0, md_valid, stall, ctrl_mult}, 32'd0);

    // 4: back-to-back mul then div.
    mi = mk_md(1'b1); di = mk_md(1'b0);
    drv(mi, 32'd5, 32'd5, 1'b0, 1'b0, 32'd0, 1'b0);
    drv(mi, 32'd5, 32'd5, 1'b0, 1'b1, 32'd25, 1'b0);
    drv(mi, 32'd5, 32'd5, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("t4_done1", {29'd0, md_valid, ctrl_mult, ctrl_div}, 32'd4);
    chk("t4_out1", md_out, 32'd25);
    drv(di, 32'd9, 32'd3, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("t4_pulse2", {30'd0, ctrl_mult, ctrl_div}, 32'd1);
    chk("t4_nocapture", md_operand_a, 32'd5);
    drv(di, 32'd9, 32'd3, 1'b0, 1'b1, 32'd3, 1'b0);
    drv(di, 32'd9, 32'd3, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("t4_out2", md_out, 32'd3);

    // 5: kill on the second busy cycle, late ready ignored.
    mi = mk_md(1'b1);
    drv(mi, 32'd2, 32'd2, 1'b0, 1'b0, 32'd0, 1'b0);
    drv(mi, 32'd2, 32'd2, 1'b0, 1'b0, 32'd0, 1'b0);
    drv(mi, 32'd2, 32'd2, 1'b1, 1'b0, 32'd0, 1'b0);
    drv(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("t5_after_kill", {30'd0, stall, md_valid}, 32'd0);
    drv(32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd4, 1'b0);
    chk("t5_late_ready", {30'd0, stall, md_valid}, 32'd0);
    drv(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("t5_quiet", {30'd0, stall, md_valid}, 32'd0);

    // 6: reset during busy with add/addi following.
    mi = mk_md(1'b1);
    drv(mi, 32'd8, 32'd8, 1'b0, 1'b0, 32'd0, 1'b0);
    drv(mi, 32'd8, 32'd8, 1'b0, 1'b0, 32'd0, 1'b0);
    @(posedge clock); #1; reset = 1'b1; insn_x = 32'd0;
    @(negedge clock);
    chk("t6_in_reset", {26'd0, ctrl_mult, ctrl_div, stall, bubble_xm, md_valid, md_write_exception}, 32'd0);
    chk("t6_opa", md_operand_a, 32'd0);
    @(posedge clock); #1; reset = 1'b0; insn_x = {5'b00101, 27'h123};
    @(negedge clock);
    chk("t6_after", {30'd0, stall, md_valid}, 32'd0);
    drv({5'b00101, 27'h456}, 32'd1, 32'd1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("t6_addi", {29'd0, stall, ctrl_mult, ctrl_div}, 32'd0);

    // Randomized traffic with a bench-side multdiv unit answering launches.
    for (int i = 0; i < 4000; i++) begin
      hold = stall;
      if (ctrl_mult || ctrl_div)
        ready_at = ($urandom_range(0, 9) == 0) ? -1 : cyc + int'($urandom_range(1, 45));
      @(posedge clock); #1;
      reset  = ($urandom_range(0, 199) == 0);
      kill_x = ($urandom_range(0, 29) == 0);
      if (!hold) begin
        r = int'($urandom_range(0, 9));
        if (r < 4) ins = mk_md(1'b1);
        else if (r < 6) ins = mk_md(1'b0);
        else begin
          ins = $urandom;
          if (classify(ins) != 2'd0) ins[6:2] = 5'b00000;
        end
        insn_x = ins; operand_a = $urandom; operand_b = $urandom;
      end
      md_ready     = (cyc == ready_at) || ($urandom_range(0, 49) == 0);
      md_result    = $urandom;
      md_exception = ($urandom_range(0, 4) == 0);
      @(negedge clock);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
